// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Oversampling UART receiver with configurable data width, parity and stop
//   bits. Each bit is decided by a 3-sample majority around mid-bit; a start
//   bit that is high at mid-bit is rejected. Frames are pushed, with their
//   parity/framing flags, into a first-word-fall-through FIFO.
//
// Ports:
//   sysclk      system clock
//   reset       synchronous active-high reset
//   UART_RX     asynchronous serial line, idle high
//   RX_READ     pop the head entry (ignored while RX_VALID=0)
//   RX_DATA     head entry data, LSB = first bit received (0 when empty)
//   RX_PERR     head entry parity error (0 when empty)
//   RX_FERR     head entry framing error (0 when empty)
//   RX_VALID    FIFO non-empty
//   RX_OVERRUN  sticky: a frame was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  input  logic                 RX_READ,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_PERR,
  output logic                 RX_FERR,
  output logic                 RX_VALID,
  output logic                 RX_OVERRUN
);

  localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = DATA_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity check: odd requires XOR(data,parity)=1, even requires 0.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] data, input logic pbit);
    logic x;
    x = ^{data, pbit};
    if (PARITY == 1)      parity_err = ~x;
    else if (PARITY == 2) parity_err = x;
    else                  parity_err = 1'b0;
  endfunction

  state_t                state_r, state_nx_s;
  logic                  meta_r, rx_s_r, rx_d_r;
  logic [TICK_W-1:0]     tick_cnt_r;
  logic [SAMP_W-1:0]     samp_cnt_r;
  logic                  samp_a_r, samp_b_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [DATA_BITS-1:0]  shift_r;
  logic                  perr_r, ferr_r, push_r, overrun_r;
  logic [EW-1:0]         mem_r [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_r, rd_ptr_r;

  logic tick_s, mid_s, end_s, maj_s, start_edge_s, last_data_s, last_stop_s;
  logic clr_cnt_s, shift_s, par_chk_s, stop_chk_s, bit_clr_s, bit_inc_s, push_set_s;
  logic empty_s, full_s, pop_s, wr_en_s;
  logic [EW-1:0] head_s;

  assign tick_s       = (tick_cnt_r == TICK_W'(DIV - 1));
  assign mid_s        = tick_s && (samp_cnt_r == SAMP_W'(MID + 1));
  assign end_s        = tick_s && (samp_cnt_r == SAMP_W'(OVERSAMPLE - 1));
  // Current rx_s_r is the third sample, taken at tick MID+1.
  assign maj_s        = (samp_a_r & samp_b_r) | (samp_a_r & rx_s_r) | (samp_b_r & rx_s_r);
  // Needs a high-to-low transition, so a line parked low never restarts a frame.
  assign start_edge_s = rx_d_r & ~rx_s_r;
  assign last_data_s  = (bit_cnt_r == BIT_W'(DATA_BITS - 1));
  assign last_stop_s  = (bit_cnt_r == BIT_W'(STOP_BITS - 1));

  // Input synchronizer (rx_s_r) and its one-cycle delayed copy (rx_d_r).
  always_ff @(posedge sysclk) begin
    if (reset) begin
      meta_r <= 1'b1;
      rx_s_r <= 1'b1;
      rx_d_r <= 1'b1;
    end else begin
      meta_r <= UART_RX;
      rx_s_r <= meta_r;
      rx_d_r <= rx_s_r;
    end
  end

  // Baud tick divider and per-bit sample counter, both realigned on a start edge.
  always_ff @(posedge sysclk) begin
    if (reset || clr_cnt_s) begin
      tick_cnt_r <= '0;
      samp_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      samp_cnt_r <= (samp_cnt_r == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt_r + SAMP_W'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Capture the first two majority samples at ticks MID-1 and MID.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else begin
      if (tick_s && (samp_cnt_r == SAMP_W'(MID - 1))) samp_a_r <= rx_s_r;
      if (tick_s && (samp_cnt_r == SAMP_W'(MID)))     samp_b_r <= rx_s_r;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) state_nx_s = ST_START;
        else              state_nx_s = ST_IDLE;
      end
      ST_START: begin
        if (mid_s && maj_s) state_nx_s = ST_IDLE;
        else if (end_s)     state_nx_s = ST_DATA;
        else                state_nx_s = ST_START;
      end
      ST_DATA: begin
        if (end_s && last_data_s) state_nx_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
        else                      state_nx_s = ST_DATA;
      end
      ST_PARITY: begin
        if (end_s) state_nx_s = ST_STOP;
        else       state_nx_s = ST_PARITY;
      end
      ST_STOP: begin
        // Leave at mid-sample of the last stop bit; the trailing half-bit is not waited out.
        if (mid_s && last_stop_s) state_nx_s = ST_IDLE;
        else                      state_nx_s = ST_STOP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes for the current state.
  always_comb begin
    clr_cnt_s  = 1'b0;
    shift_s    = 1'b0;
    par_chk_s  = 1'b0;
    stop_chk_s = 1'b0;
    bit_clr_s  = 1'b0;
    bit_inc_s  = 1'b0;
    push_set_s = 1'b0;
    case (state_r)
      ST_IDLE:   clr_cnt_s = start_edge_s;
      ST_START:  bit_clr_s = end_s;
      ST_DATA: begin
        shift_s   = mid_s;
        bit_clr_s = end_s & last_data_s;
        bit_inc_s = end_s & ~last_data_s;
      end
      ST_PARITY: begin
        par_chk_s = mid_s;
        bit_clr_s = end_s;
      end
      ST_STOP: begin
        stop_chk_s = mid_s;
        push_set_s = mid_s & last_stop_s;
        bit_inc_s  = end_s;
      end
      default: clr_cnt_s = 1'b0;
    endcase
  end

  // Frame datapath: bit counter, shift register, error flags, push strobe.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      bit_cnt_r <= '0;
      shift_r   <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      push_r    <= 1'b0;
    end else begin
      push_r <= push_set_s;
      if (clr_cnt_s || bit_clr_s) bit_cnt_r <= '0;
      else if (bit_inc_s)         bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      if (shift_s) shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
      if (clr_cnt_s)      perr_r <= 1'b0;
      else if (par_chk_s) perr_r <= parity_err(shift_r, maj_s);
      if (clr_cnt_s)                 ferr_r <= 1'b0;
      else if (stop_chk_s && !maj_s) ferr_r <= 1'b1;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = RX_READ & ~empty_s;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign wr_en_s = push_r & (~full_s | pop_s);

  // FIFO storage, pointers and sticky overrun flag.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      overrun_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= {shift_r, perr_r, ferr_r};
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      if (push_r && full_s && !pop_s) overrun_r <= 1'b1;
    end
  end

  assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
  assign RX_VALID   = ~empty_s;
  assign RX_DATA    = empty_s ? '0   : head_s[EW-1:2];
  assign RX_PERR    = empty_s ? 1'b0 : head_s[1];
  assign RX_FERR    = empty_s ? 1'b0 : head_s[0];
  assign RX_OVERRUN = overrun_r;

endmodule
